// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the pipeline step controller.
package pipe_ctrl_pkg;

    localparam int unsigned DEF_RUN_DIV = 50000000;
    localparam int unsigned DEF_CNT_W   = 28;
    localparam int unsigned DEF_CYC_W   = 16;
    localparam int unsigned BURST_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STEP   = 3'd1,
        ST_RUN    = 3'd2,
        ST_BURST  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

endpackage

// File: rtl/pipe_step_if.sv
// Button-side commands in, pipeline advance and display status out.
interface pipe_step_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CYC_W = DEF_CYC_W
);
    logic               step_pulse;
    logic               run_pulse;
    logic               burst_pulse;
    logic [BURST_W-1:0] burst_len;
    logic               halt_req;
    logic               adv;
    logic               running;
    logic               halted;
    logic [CYC_W-1:0]   cycle_count;

    modport master (
        output step_pulse, run_pulse, burst_pulse, burst_len, halt_req,
        input  adv, running, halted, cycle_count
    );

    modport slave (
        input  step_pulse, run_pulse, burst_pulse, burst_len, halt_req,
        output adv, running, halted, cycle_count
    );
endinterface

// File: rtl/pipe_step_controller_rate_divider.sv
// Reloading down-counter that paces free-run advances.
module rate_divider #(
    parameter int unsigned W = 28
) (
    input  logic         CLK,
    input  logic         clear_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero_nxt_c
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: explicit load, or decrement with wrap back to the reload value.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec) begin
            cnt_d = (cnt_q == '0) ? load_val : cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry is flagged one cycle early so the registered advance lands on count==0.
    assign zero_nxt_c = (cnt_d == '0);

endmodule

// File: rtl/pipe_step_controller.sv
// Single-step / burst / free-run sequencer for the pipeline advance enable.
module pipe_step_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DIV = DEF_RUN_DIV,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned CYC_W   = DEF_CYC_W
) (
    input  logic      CLK,
    input  logic      clear_n,
    pipe_step_if.slave bus
);
    localparam logic [CNT_W-1:0] DIV_RELOAD = CNT_W'(RUN_DIV - 1);

    state_e             state_q;
    state_e             state_d;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W-1:0] burst_d;
    logic [CYC_W-1:0]   cyc_q;
    logic               adv_q;
    logic               running_q;
    logic               halted_q;
    logic               adv_d;
    logic               div_load;
    logic               div_dec;
    logic               div_zero_nxt_c;

    rate_divider #(
        .W (CNT_W)
    ) u_div (
        .CLK        (CLK),
        .clear_n    (clear_n),
        .load       (div_load),
        .dec        (div_dec),
        .load_val   (DIV_RELOAD),
        .zero_nxt_c (div_zero_nxt_c)
    );

    // Next state, burst count and divider control; halt outranks every pulse.
    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        div_load = 1'b0;
        div_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (bus.run_pulse) begin
                    state_d  = ST_RUN;
                    div_load = 1'b1;
                end else if (bus.burst_pulse) begin
                    if (bus.burst_len != '0) begin
                        state_d = ST_BURST;
                        burst_d = bus.burst_len;
                    end
                end else if (bus.step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                state_d = bus.halt_req ? ST_HALTED : ST_IDLE;
            end
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                end else if (bus.run_pulse) begin
                    state_d = ST_IDLE;
                end else begin
                    div_dec = 1'b1;
                end
            end
            ST_BURST: begin
                if (bus.halt_req) begin
                    state_d = ST_HALTED;
                    burst_d = '0;
                end else if (bus.run_pulse || burst_q <= BURST_W'(1)) begin
                    state_d = ST_IDLE;
                    burst_d = '0;
                end else begin
                    burst_d = burst_q - BURST_W'(1);
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
                burst_d = '0;
            end
        endcase
    end

    // Advance decision for the upcoming cycle, decoded from the next state.
    always_comb begin
        adv_d = 1'b0;
        unique case (state_d)
            ST_STEP, ST_BURST: adv_d = 1'b1;
            ST_RUN:            adv_d = div_zero_nxt_c;
            default:           adv_d = 1'b0;
        endcase
    end

    // State, burst counter, registered outputs and saturating advance count.
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= ST_IDLE;
            burst_q   <= '0;
            adv_q     <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            cyc_q     <= '0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            adv_q     <= adv_d;
            running_q <= (state_d == ST_RUN) || (state_d == ST_BURST);
            halted_q  <= (state_d == ST_HALTED);
            if (adv_d && (cyc_q != '1)) begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
        end
    end

    assign bus.adv         = adv_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.cycle_count = cyc_q;

endmodule

// File: tb/tb_pipe_step_controller.sv
// Scoreboard bench: stimulus queues expected advances, a negedge monitor checks them.
module tb_pipe_step_controller;

    localparam int unsigned RUN_DIV = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CYC_W   = 4;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic CLK;
    logic clear_n;
    int   cyc;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    pipe_step_if #(.CYC_W(CYC_W)) bus ();

    pipe_step_controller #(
        .RUN_DIV (RUN_DIV),
        .CNT_W   (CNT_W),
        .CYC_W   (CYC_W)
    ) dut (
        .CLK     (CLK),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_adv(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every advance must match the next queued expectation.
    always @(negedge CLK) begin
        if (clear_n && bus.adv) begin
            if (exp_q.size() == 0) begin
                check("unexpected_adv_cycle", cyc, -1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("adv_cycle", cyc, e.cyc);
                check("adv_cycle_count", int'(bus.cycle_count), e.cnt);
            end
        end
    end

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input logic s, input logic r, input logic b, input logic h,
                         input logic [3:0] len);
        bus.step_pulse  = s;
        bus.run_pulse   = r;
        bus.burst_pulse = b;
        bus.halt_req    = h;
        bus.burst_len   = len;
        next_cyc();
        bus.step_pulse  = 1'b0;
        bus.run_pulse   = 1'b0;
        bus.burst_pulse = 1'b0;
        bus.halt_req    = 1'b0;
        bus.burst_len   = 4'd0;
    endtask

    task automatic do_reset();
        next_cyc();
        clear_n = 1'b0;
        #1;
        check("rst_adv", int'(bus.adv), 0);
        check("rst_running", int'(bus.running), 0);
        check("rst_halted", int'(bus.halted), 0);
        check("rst_cycle_count", int'(bus.cycle_count), 0);
        repeat (2) @(posedge CLK);
        #1;
        clear_n = 1'b1;
        next_cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        errors          = 0;
        checks          = 0;
        clear_n         = 1'b1;
        bus.step_pulse  = 1'b0;
        bus.run_pulse   = 1'b0;
        bus.burst_pulse = 1'b0;
        bus.halt_req    = 1'b0;
        bus.burst_len   = 4'd0;

        // Single step: adv exactly one cycle after the pulse.
        do_reset();
        repeat (8) next_cyc();
        t = cyc;
        expect_adv(t + 1, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (4) next_cyc();
        check("step_count", int'(bus.cycle_count), 1);
        check("step_running", int'(bus.running), 0);
        check("step_pending", exp_q.size(), 0);

        // Free run: adv every RUN_DIV cycles, stop on second run pulse.
        do_reset();
        t = cyc;
        expect_adv(t + 4, 1);
        expect_adv(t + 8, 2);
        expect_adv(t + 12, 3);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        next_cyc();
        check("run_running", int'(bus.running), 1);
        repeat (11) next_cyc();
        check("run_stop_cycle", cyc, t + 13);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (8) next_cyc();
        check("run_count", int'(bus.cycle_count), 3);
        check("run_stopped", int'(bus.running), 0);
        check("run_pending", exp_q.size(), 0);

        // Burst of 5, then a zero-length burst that must do nothing.
        do_reset();
        t = cyc;
        for (int i = 1; i <= 5; i++) expect_adv(t + i, i);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
        check("burst_running", int'(bus.running), 1);
        repeat (7) next_cyc();
        check("burst_count", int'(bus.cycle_count), 5);
        check("burst_done_running", int'(bus.running), 0);
        check("burst_pending", exp_q.size(), 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("burst0_running", int'(bus.running), 0);
        repeat (4) next_cyc();
        check("burst0_count", int'(bus.cycle_count), 5);

        // Halt in the cycle the divider expires: that advance is suppressed, halt is sticky.
        do_reset();
        t = cyc;
        expect_adv(t + 4, 1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (6) next_cyc();
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("halt_halted", int'(bus.halted), 1);
        check("halt_running", int'(bus.running), 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        next_cyc();
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (8) next_cyc();
        check("halt_sticky", int'(bus.halted), 1);
        check("halt_count", int'(bus.cycle_count), 1);
        check("halt_pending", exp_q.size(), 0);
        do_reset();
        check("halt_cleared", int'(bus.halted), 0);
        t = cyc;
        expect_adv(t + 1, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) next_cyc();
        check("post_halt_pending", exp_q.size(), 0);

        // Simultaneous pulses: run beats step, halt beats step.
        do_reset();
        t = cyc;
        expect_adv(t + 4, 1);
        pulse(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        check("prio_running", int'(bus.running), 1);
        repeat (4) next_cyc();
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        repeat (5) next_cyc();
        check("prio_count", int'(bus.cycle_count), 1);
        check("prio_pending", exp_q.size(), 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        check("prio_halted", int'(bus.halted), 1);
        repeat (3) next_cyc();
        check("prio_halt_count", int'(bus.cycle_count), 1);

        // Saturation: 20 steps on a 4-bit counter stop at 15.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            t = cyc;
            expect_adv(t + 1, (i + 1 > 15) ? 15 : i + 1);
            pulse(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            next_cyc();
        end
        next_cyc();
        check("sat_count", int'(bus.cycle_count), 15);
        check("sat_pending", exp_q.size(), 0);

        // Asynchronous clear in the middle of a burst.
        do_reset();
        t = cyc;
        for (int i = 1; i <= 3; i++) expect_adv(t + i, i);
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'd8);
        repeat (2) next_cyc();
        #6;
        clear_n = 1'b0;
        #1;
        check("async_adv", int'(bus.adv), 0);
        check("async_count", int'(bus.cycle_count), 0);
        check("async_running", int'(bus.running), 0);
        repeat (2) @(posedge CLK);
        #1;
        clear_n = 1'b1;
        repeat (8) next_cyc();
        check("async_pending", exp_q.size(), 0);
        check("async_after_count", int'(bus.cycle_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
